// File: rtl/mul_iter_if.sv
`default_nettype none
// =============================================================================
// mul_iter_if : EX-stage handshake between the core and the iterative multiplier
// Rev 1.0
// =============================================================================
interface mul_iter_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [1:0]       funct3;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             stall;
    logic             mul_ready;
    logic [WIDTH-1:0] mul_out;

    modport master (
        output valid, funct3, rs1_data, rs2_data,
        input  stall, mul_ready, mul_out
    );

    modport slave (
        input  valid, funct3, rs1_data, rs2_data,
        output stall, mul_ready, mul_out
    );
endinterface
`default_nettype wire

// File: rtl/mul_iter_unit.sv
`default_nettype none
// =============================================================================
// mul_iter_unit : iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Rev 1.0
// =============================================================================
module mul_iter_unit #(
    parameter int WIDTH = 32
) (
    input wire        clk,
    input wire        rst_n,
    mul_iter_if.slave bus
);
    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_low;
    logic [WIDTH-1:0]   r_out;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;

    // Operand A is signed for MULH/MULHSU, operand B only for MULH.
    assign w_sign_a  = (bus.funct3 == 2'b01 || bus.funct3 == 2'b10) && bus.rs1_data[WIDTH-1];
    assign w_sign_b  = (bus.funct3 == 2'b01) && bus.rs2_data[WIDTH-1];
    assign w_mag_a   = w_sign_a ? -bus.rs1_data : bus.rs1_data;
    assign w_mag_b   = w_sign_b ? -bus.rs2_data : bus.rs2_data;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Full-width negate so the high word of mixed-sign products is correct.
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.valid) w_next = c_BUSY;
            c_BUSY:  if (r_cnt == c_LAST) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.stall     = 1'b0;
        bus.mul_ready = 1'b0;
        case (r_state)
            c_IDLE:  bus.stall     = bus.valid;
            c_BUSY:  bus.stall     = 1'b1;
            c_DONE:  bus.mul_ready = 1'b1;
            default: ;
        endcase
    end

    // The result register is loaded on the final iteration so it is valid during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_low    <= 1'b0;
            r_out    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_sign_a ^ w_sign_b;
                        r_low    <= (bus.funct3 == 2'b00);
                    end
                end
                c_BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_out <= r_low ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_out = r_out;

endmodule
`default_nettype wire
